register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width in bits (legal range 1..64).
REQ-002 The module SHALL have parameter RESET_VALUE, default all-zeros, WIDTH bits, giving the value loaded on reset.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 8, giving the load-counter width in bits.
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port load, input, 1 bit: capture data_in at the next rising clk edge.
REQ-008 Port data_in, input, WIDTH bits: value to capture.
REQ-009 Port data_out, output, WIDTH bits: current stored value, driven directly from a flop.
REQ-010 Port data_prev, output, WIDTH bits: value data_out held before the most recent load.
REQ-011 Port loaded, output, 1 bit: high once at least one load has occurred since reset.
REQ-012 Port changed, output, 1 bit: one-cycle pulse after a load that altered data_out.
REQ-013 Port load_count, output, CNT_WIDTH bits: saturating count of loads since reset.

Function
REQ-014 While rst is low and load is high, each rising clk edge SHALL set data_out to data_in, with a latency of one edge.
REQ-015 While rst is low and load is low, data_out SHALL hold its value indefinitely.
REQ-016 On each load, data_prev SHALL take the old data_out value; otherwise data_prev SHALL hold.
REQ-017 loaded SHALL go high on the first load edge after reset and stay high until the next reset.
REQ-018 changed SHALL be high for exactly the one cycle after a load edge where data_in differs from the old data_out; otherwise it SHALL be low.
REQ-019 Reloading the same value SHALL leave changed low, while still updating data_prev and load_count.
REQ-020 load_count SHALL increment by 1 on each load edge and saturate at all-ones with no wrap-around.
REQ-021 rst SHALL take priority over load: with both high, the reset value wins.
REQ-022 X or Z on data_in during a load SHALL propagate to data_out; no sanitising.

Reset
REQ-023 While rst is high, outputs SHALL be set asynchronously, without waiting for a clk edge, as follows: data_out = RESET_VALUE, data_prev = RESET_VALUE, loaded = 0, changed = 0, load_count = 0.
REQ-024 Deasserting rst SHALL cause no state change by itself; the first load takes effect at the first rising edge with rst low.
REQ-025 A reset asserted in the middle of a cycle SHALL override any load pending for that cycle.

Structure
REQ-026 A shared package register_pkg SHALL hold the default constants: DEFAULT_WIDTH = 8 and DEFAULT_CNT_WIDTH = 8.
REQ-027 The saturating counter SHALL be implemented as sub-module register_sat_counter (ports clk, rst, inc, count).
REQ-028 All remaining logic SHALL be implemented in register itself, with no latches and with registered outputs only.

Verification (WIDTH=8, checks at falling edges)
REQ-029 Load sequence: rst=0, load=1, data_in=0x55, then 0xAA, then 0xFF -> data_out = 0x55, 0xAA, 0xFF after successive edges; data_prev = 0x00, 0x55, 0xAA; load_count = 1, 2, 3.
REQ-030 Reset beats load: rst=1, load=1, data_in=0xFF -> data_out = 0x00, loaded = 0, load_count = 0.
REQ-031 Hold: load 0x3C, then load=0 for 3 cycles with data_in=0xC3 -> data_out stays 0x3C, and changed pulses only once.
REQ-032 Asynchronous reset: with data_out = 0xAA, raise rst between edges -> data_out = 0x00 before the next rising edge.
REQ-033 Same-value reload: load 0x55 twice -> changed is 1 then 0, and load_count increments both times.
REQ-034 Saturation: with CNT_WIDTH=2, perform 5 loads -> load_count = 3 and stays 3.

Source files
------------

// File: rtl/register_pkg.sv
// Shared constants for the register block and its load counter.
package register_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_CNT_WIDTH = 8;

endpackage : register_pkg

// File: rtl/register_sat_counter.sv
// Saturating up-counter: advances by one per inc cycle and sticks at all-ones.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears count
//   inc   - increment request for this edge
//   count - registered count value
module register_sat_counter
    import register_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    // Count register; holds once saturated so it never wraps to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : register_sat_counter

// File: rtl/register.sv
// Loadable data register with history, first-load flag, change pulse and
// saturating load counter.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (beats load)
//   load       - capture data_in at the next rising edge
//   data_in    - value to capture
//   data_out   - current stored value (flop output)
//   data_prev  - data_out value before the most recent load
//   loaded     - high once any load has happened since reset
//   changed    - one-cycle pulse after a load that altered data_out
//   load_count - saturating number of loads since reset
module register
    import register_pkg::*;
#(
    parameter int unsigned             WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]        RESET_VALUE = '0,
    parameter int unsigned             CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     data_out,
    output logic [WIDTH-1:0]     data_prev,
    output logic                 loaded,
    output logic                 changed,
    output logic [CNT_WIDTH-1:0] load_count
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_data_prev;
    logic             r_loaded;
    logic             r_changed;
    logic             w_differs;

    // Compare against the value being replaced; X on data_in yields X here
    // rather than being forced to a known level.
    assign w_differs = (data_in != r_data_out);

    // Data, history and status flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= RESET_VALUE;
            r_data_prev <= RESET_VALUE;
            r_loaded    <= 1'b0;
            r_changed   <= 1'b0;
        end else begin
            r_changed <= load && w_differs;
            if (load) begin
                r_data_prev <= r_data_out;
                r_data_out  <= data_in;
                r_loaded    <= 1'b1;
            end
        end
    end

    register_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (load),
        .count (load_count)
    );

    assign data_out  = r_data_out;
    assign data_prev = r_data_prev;
    assign loaded    = r_loaded;
    assign changed   = r_changed;

endmodule : register

// File: tb/tb_register.sv
// Scoreboard bench for register: a default-width instance and a second one
// with a 2-bit load counter, both driven by the same stimulus.
module tb_register;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data_in;

    logic [7:0] data_out,  data_prev;
    logic       loaded,    changed;
    logic [7:0] load_count;

    logic [7:0] data_out2, data_prev2;
    logic       loaded2,   changed2;
    logic [1:0] load_count2;

    register #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_prev  (data_prev),
        .loaded     (loaded),
        .changed    (changed),
        .load_count (load_count)
    );

    register #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_WIDTH(2)) u_dut_sat (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .data_out   (data_out2),
        .data_prev  (data_prev2),
        .loaded     (loaded2),
        .changed    (changed2),
        .load_count (load_count2)
    );

    typedef struct {
        string      tag;
        logic [7:0] dout;
        logic [7:0] dprev;
        logic       ldd;
        logic       chg;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t q[$];

    // Reference model state
    logic [7:0] m_out, m_prev, m_cnt;
    logic       m_loaded, m_changed;
    logic [1:0] m_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out     = 8'h00;
        m_prev    = 8'h00;
        m_loaded  = 1'b0;
        m_changed = 1'b0;
        m_cnt     = 8'h00;
        m_cnt2    = 2'b00;
    endtask

    // Drive one cycle, push the model's prediction, then compare at the falling edge.
    task automatic drive_cycle(input string tag, input logic r, input logic l, input logic [7:0] d);
        exp_t e;
        exp_t g;
        rst     = r;
        load    = l;
        data_in = d;
        if (r) begin
            model_reset();
        end else begin
            m_changed = l && (d != m_out);
            if (l) begin
                m_prev   = m_out;
                m_out    = d;
                m_loaded = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
            end
        end
        e.tag = tag; e.dout = m_out; e.dprev = m_prev; e.ldd = m_loaded;
        e.chg = m_changed; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (q.size() == 0) begin
            check({tag, ".queue_empty"}, 64'd1, 64'd0);
        end else begin
            g = q.pop_front();
            check({g.tag, ".data_out"},    64'(data_out),    64'(g.dout));
            check({g.tag, ".data_prev"},   64'(data_prev),   64'(g.dprev));
            check({g.tag, ".loaded"},      64'(loaded),      64'(g.ldd));
            check({g.tag, ".changed"},     64'(changed),     64'(g.chg));
            check({g.tag, ".load_count"},  64'(load_count),  64'(g.cnt));
            check({g.tag, ".data_out2"},   64'(data_out2),   64'(g.dout));
            check({g.tag, ".data_prev2"},  64'(data_prev2),  64'(g.dprev));
            check({g.tag, ".loaded2"},     64'(loaded2),     64'(g.ldd));
            check({g.tag, ".changed2"},    64'(changed2),    64'(g.chg));
            check({g.tag, ".load_count2"}, 64'(load_count2), 64'(g.cnt2));
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = 8'h00;
        model_reset();

        drive_cycle("reset", 1'b1, 1'b0, 8'h00);
        drive_cycle("reset_hold", 1'b1, 1'b1, 8'h77);
        drive_cycle("deassert_no_load", 1'b0, 1'b0, 8'h12);

        // Load sequence
        drive_cycle("seq_55", 1'b0, 1'b1, 8'h55);
        drive_cycle("seq_AA", 1'b0, 1'b1, 8'hAA);
        drive_cycle("seq_FF", 1'b0, 1'b1, 8'hFF);

        // Reset beats load
        drive_cycle("rst_vs_load", 1'b1, 1'b1, 8'hFF);

        // Hold with changing data_in
        drive_cycle("hold_load", 1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) drive_cycle("hold_idle", 1'b0, 1'b0, 8'hC3);

        // Same-value reload
        drive_cycle("same_first", 1'b0, 1'b1, 8'h55);
        drive_cycle("same_again", 1'b0, 1'b1, 8'h55);

        // Push the 2-bit counter past saturation
        drive_cycle("sat_4", 1'b0, 1'b1, 8'h01);
        drive_cycle("sat_5", 1'b0, 1'b1, 8'h02);
        drive_cycle("sat_6", 1'b0, 1'b1, 8'h03);

        // Asynchronous reset between edges
        drive_cycle("pre_async", 1'b0, 1'b1, 8'hAA);
        #2 rst = 1'b1;
        #1;
        check("async.data_out",   64'(data_out),   64'h00);
        check("async.data_prev",  64'(data_prev),  64'h00);
        check("async.loaded",     64'(loaded),     64'h0);
        check("async.load_count", 64'(load_count), 64'h0);
        @(negedge clk);
        model_reset();
        drive_cycle("async_release", 1'b0, 1'b0, 8'h99);

        // Random traffic with occasional resets
        for (int i = 0; i < 40; i++) begin
            drive_cycle("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                        8'($urandom_range(0, 3) == 0 ? m_out : 8'($urandom)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_register
